// File: rtl/borrow_chain_subtractor_if.sv
// borrow_chain_subtractor_if: operand/result handshake bundle for the subtractor.
// Ovf exists only when SUB_OVF_EN is defined.
interface borrow_chain_subtractor_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Zero;
`ifdef SUB_OVF_EN
    logic             Ovf;
    modport master (output in_valid, A, B, Bin, out_ready, input in_ready, out_valid, Diff, Bout, Zero, Ovf);
    modport slave (input in_valid, A, B, Bin, out_ready, output in_ready, out_valid, Diff, Bout, Zero, Ovf);
`else
    modport master (output in_valid, A, B, Bin, out_ready, input in_ready, out_valid, Diff, Bout, Zero);
    modport slave (input in_valid, A, B, Bin, out_ready, output in_ready, out_valid, Diff, Bout, Zero);
`endif
endinterface

// File: rtl/borrow_chain_subtractor.sv
// borrow_chain_subtractor: multi-cycle A - B - Bin, one SLICE-bit borrow-ripple slice per clock.
// Optional signed overflow output Ovf enabled by SUB_OVF_EN.
module borrow_chain_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic clk,
    input logic rst,
    borrow_chain_subtractor_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, diff_nx;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    base;
    logic [SLICE-1:0] a_s, b_s, d;
    logic [SLICE:0]   chain;
    logic             last;

    assign base = IW'(cnt) * IW'(SLICE);
    assign a_s  = a_r[base +: SLICE];
    assign b_s  = b_r[base +: SLICE];
    assign last = cnt == CW'(N - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && bus.in_valid) state_nx = BUSY;
        else if (state == BUSY && last) state_nx = DONE;
        else if (state == DONE && bus.out_ready) state_nx = IDLE;
    end

    always_comb begin
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
    end

    // chain[0] is the borrow carried in from the previous slice
    always_comb begin
        d     = '0;
        chain = '0;
        chain[0] = br;
        for (int i = 0; i < SLICE; i++) begin
            d[i]       = a_s[i] ^ b_s[i] ^ chain[i];
            chain[i+1] = (~a_s[i] & b_s[i]) | (~(a_s[i] ^ b_s[i]) & chain[i]);
        end
        diff_nx = bus.Diff;
        diff_nx[base +: SLICE] = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            bus.Diff <= '0;
            bus.Bout <= 1'b0;
            bus.Zero <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            a_r <= bus.A;
            b_r <= bus.B;
            br  <= bus.Bin;
            cnt <= '0;
        end else if (state == BUSY) begin
            bus.Diff <= diff_nx;
            br       <= chain[SLICE];
            cnt      <= cnt + 1'b1;
            if (last) begin
                bus.Bout <= chain[SLICE];
                bus.Zero <= diff_nx == '0;
            end
        end
    end

`ifdef SUB_OVF_EN
    // signed overflow: borrow into the MSB differs from borrow out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.Ovf <= 1'b0;
        else if (state == BUSY && last) bus.Ovf <= chain[SLICE-1] ^ chain[SLICE];
    end
`endif
endmodule

// File: tb/tb_borrow_chain_subtractor.sv
// tb_borrow_chain_subtractor: directed vector table plus backpressure, reset-abort and streaming sequences.
module tb_borrow_chain_subtractor;
    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    borrow_chain_subtractor_if #(.WIDTH(WIDTH)) bus ();
    borrow_chain_subtractor #(.WIDTH(WIDTH), .SLICE(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 1);
        bus.A = a;
        bus.B = b;
        bus.Bin = bin;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle_after_retire", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[10];
        int          lat;
        int          lastc;
        int          got;
        int          ones;
        logic [16:0] q[$];
        logic [16:0] e;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0007, 16'h0007, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{16'h00F0, 16'h000F, 1'b1, 16'h00E0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Bin = 1'b0;

        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_diff", 32'(bus.Diff), 0);
        chk("rst_bout_zero", {30'd0, bus.Bout, bus.Zero}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, 4);
            chk($sformatf("v%0d_diff", i), 32'(bus.Diff), 32'(vecs[i].diff));
            chk($sformatf("v%0d_bout", i), 32'(bus.Bout), 32'(vecs[i].bout));
            chk($sformatf("v%0d_zero", i), 32'(bus.Zero), 32'(vecs[i].zero));
`ifdef SUB_OVF_EN
            chk($sformatf("v%0d_ovf", i), 32'(bus.Ovf), 32'(vecs[i].ovf));
`endif
            retire();
        end

        // backpressure: result held while new operands are offered
        issue(16'h1234, 16'h0234, 1'b0);
        wait_done(lat);
        for (int k = 0; k < 3; k++) begin
            bus.A = 16'($urandom);
            bus.B = 16'($urandom);
            bus.Bin = 1'b1;
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 1);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_diff", 32'(bus.Diff), 32'h1000);
            chk("bp_bout_zero", {30'd0, bus.Bout, bus.Zero}, 0);
        end
        bus.in_valid = 1'b0;
        retire();

        // reset while cnt == 2 aborts the operation
        issue(16'h1234, 16'h0234, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        chk("abort_diff", 32'(bus.Diff), 0);
        @(negedge clk);
        rst = 1'b0;
        ones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.out_valid) ones++;
        end
        chk("abort_no_pulse", ones, 0);
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat);
        chk("post_abort_latency", lat, 4);
        chk("post_abort_diff", 32'(bus.Diff), 32'hFFFE);
        chk("post_abort_bout", 32'(bus.Bout), 0);
        retire();

        // streaming with both handshakes held high
        got = 0;
        lastc = -1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (bus.out_valid) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("stream_diff", 32'(bus.Diff), 32'(e[15:0]));
                    chk("stream_bout", 32'(bus.Bout), 32'(e[16]));
                end else chk("stream_unexpected", 1, 0);
                if (lastc >= 0) chk("stream_gap", c - lastc, 6);
                lastc = c;
                got++;
            end
            if (bus.in_ready) begin
                bus.A = 16'($urandom);
                bus.B = 16'($urandom);
                bus.Bin = 1'($urandom_range(0, 1));
                q.push_back({1'b0, bus.A} - {1'b0, bus.B} - 17'(bus.Bin));
            end
            @(negedge clk);
        end
        chk("stream_count", got, 11);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        bus.out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
